// File: rtl/z_mem_responder.sv
// z_mem_responder: depth-buffer memory responder for the depth-test buf_* /
// data_r_* / data_w_* interface. Single-cycle writes, 3-cycle reads with a
// valid/ready response, sticky out-of-range flag.
// Optional frame clear (sweep to CLEAR_VALUE) is built when ZMEM_CLEAR_EN is
// defined; without it clear_i is ignored and clear_done_o is tied low.
module z_mem_responder #(
    parameter int                Z_SIZE      = 8,
    parameter int                X_RES       = 1280,
    parameter int                Y_RES       = 720,
    parameter int                DEPTH_WORDS = X_RES * Y_RES,
    parameter int                ADDR_SIZE   = 32,
    parameter logic [Z_SIZE-1:0] CLEAR_VALUE = {Z_SIZE{1'b1}}
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_SIZE-1:0] buf_base_address_i,
    input  logic                 buf_r_w,
    input  logic [ADDR_SIZE-1:0] buf_addr,
    input  logic [Z_SIZE-1:0]    buf_data_w,
    output logic [Z_SIZE-1:0]    buf_data_r,
    input  logic                 data_r_ready,
    output logic                 data_r_valid,
    input  logic                 data_w_valid,
    output logic                 data_w_ready,
    input  logic                 clear_i,
    output logic                 clear_done_o,
    output logic                 busy_o,
    output logic                 oor_o
);

    localparam int                   AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [AW-1:0]        LAST_IDX = AW'(DEPTH_WORDS - 1);
    localparam logic [ADDR_SIZE-1:0] DEPTH_A  = ADDR_SIZE'(DEPTH_WORDS);

`ifdef ZMEM_CLEAR_EN
    typedef enum logic [1:0] {IDLE, RD, RESP, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, RD, RESP} state_t;
`endif

    state_t                 state;
    state_t                 state_next;

    logic [Z_SIZE-1:0]      ram [DEPTH_WORDS];

    logic [ADDR_SIZE-1:0]   offset;
    logic                   req_oor;
    logic                   rd_accept;
    logic [AW-1:0]          rd_offset;
    logic                   rd_oor;

    logic                   ram_we;
    logic [AW-1:0]          ram_waddr;
    logic [Z_SIZE-1:0]      ram_wdata;

`ifdef ZMEM_CLEAR_EN
    logic [AW-1:0]          clr_cnt;
    logic                   clear_pend;
`else
    logic                   unused_clear;
    assign unused_clear = clear_i;
    assign clear_done_o = 1'b0;
`endif

    // Address translation; a request below the base wraps and is caught by the explicit compare.
    assign offset  = buf_addr - buf_base_address_i;
    assign req_oor = (buf_addr < buf_base_address_i) || (offset >= DEPTH_A);

    assign data_r_valid = (state == RESP);
    assign busy_o       = (state != IDLE);

    // Next-state, write-acknowledge and RAM write-port selection.
    always_comb begin
        state_next   = state;
        data_w_ready = 1'b0;
        rd_accept    = 1'b0;
        ram_we       = 1'b0;
        ram_waddr    = offset[AW-1:0];
        ram_wdata    = buf_data_w;
        case (state)
            IDLE: begin
`ifdef ZMEM_CLEAR_EN
                if (clear_i) begin
                    state_next = CLEAR;
                end else
`endif
                if (!buf_r_w && data_w_valid) begin
                    data_w_ready = 1'b1;
                    ram_we       = !req_oor;
                end else if (buf_r_w && data_r_ready) begin
                    rd_accept  = 1'b1;
                    state_next = RD;
                end
            end
            RD: begin
                state_next = RESP;
            end
            RESP: begin
                if (data_r_ready) begin
`ifdef ZMEM_CLEAR_EN
                    state_next = (clear_pend || clear_i) ? CLEAR : IDLE;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef ZMEM_CLEAR_EN
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt;
                ram_wdata = CLEAR_VALUE;
                if (clr_cnt == LAST_IDX) begin
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Depth RAM write port; contents are never reset, and writes are held off while reset is asserted.
    always_ff @(posedge clk_i) begin
        if (ram_we && !rst_i) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    // State register, read pipeline, sticky out-of-range flag and clear sweep control.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            rd_offset  <= '0;
            rd_oor     <= 1'b0;
            buf_data_r <= '0;
            oor_o      <= 1'b0;
`ifdef ZMEM_CLEAR_EN
            clr_cnt      <= '0;
            clear_pend   <= 1'b0;
            clear_done_o <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (rd_accept) begin
                rd_offset <= offset[AW-1:0];
                rd_oor    <= req_oor;
            end
            if (state == RD) begin
                buf_data_r <= rd_oor ? CLEAR_VALUE : ram[rd_offset];
            end
            if ((rd_accept || data_w_ready) && req_oor) begin
                oor_o <= 1'b1;
            end
`ifdef ZMEM_CLEAR_EN
            clear_done_o <= (state == CLEAR) && (clr_cnt == LAST_IDX);
            // Entry into CLEAR (from IDLE or straight after a response transfer) restarts the sweep.
            if (state_next == CLEAR && state != CLEAR) begin
                oor_o      <= 1'b0;
                clr_cnt    <= '0;
                clear_pend <= 1'b0;
            end else begin
                if (state == CLEAR && clr_cnt != LAST_IDX) begin
                    clr_cnt <= clr_cnt + 1'b1;
                end
                if ((state == RD || state == RESP) && clear_i) begin
                    clear_pend <= 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_z_mem_responder.sv
// Self-checking bench for z_mem_responder (16-word RAM, base 0x100).
// Randomized reads/writes against an array reference model; clear-path
// sequences are compiled only when ZMEM_CLEAR_EN is defined.
module tb_z_mem_responder;

    localparam int          DW   = 16;
    localparam logic [31:0] BASE = 32'h100;
    localparam logic [7:0]  CV   = 8'hFF;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] buf_base_address_i;
    logic        buf_r_w;
    logic [31:0] buf_addr;
    logic [7:0]  buf_data_w;
    logic [7:0]  buf_data_r;
    logic        data_r_ready;
    logic        data_r_valid;
    logic        data_w_valid;
    logic        data_w_ready;
    logic        clear_i;
    logic        clear_done_o;
    logic        busy_o;
    logic        oor_o;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem_m [DW];
    logic        oor_m;

    z_mem_responder #(
        .Z_SIZE      (8),
        .DEPTH_WORDS (DW),
        .ADDR_SIZE   (32),
        .CLEAR_VALUE (CV)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .buf_base_address_i (buf_base_address_i),
        .buf_r_w            (buf_r_w),
        .buf_addr           (buf_addr),
        .buf_data_w         (buf_data_w),
        .buf_data_r         (buf_data_r),
        .data_r_ready       (data_r_ready),
        .data_r_valid       (data_r_valid),
        .data_w_valid       (data_w_valid),
        .data_w_ready       (data_w_ready),
        .clear_i            (clear_i),
        .clear_done_o       (clear_done_o),
        .busy_o             (busy_o),
        .oor_o              (oor_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(DW));
    endfunction

    function automatic logic [3:0] widx(input logic [31:0] a);
        return 4'(a - BASE);
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk_i);
        buf_r_w      = 1'b0;
        buf_addr     = a;
        buf_data_w   = d;
        data_w_valid = 1'b1;
        data_r_ready = 1'b0;
        #1 check("wr_ready", data_w_ready, 1);
        @(posedge clk_i);
        #1 data_w_valid = 1'b0;
        if (in_range(a)) mem_m[widx(a)] = d;
        else oor_m = 1'b1;
        check("wr_oor", oor_o, oor_m);
    endtask

    task automatic do_read(input logic [31:0] a, input int hold);
        logic [7:0] exp;
        @(negedge clk_i);
        buf_r_w      = 1'b1;
        buf_addr     = a;
        data_r_ready = 1'b1;
        data_w_valid = 1'b0;
        @(posedge clk_i);
        #1;
        exp = in_range(a) ? mem_m[widx(a)] : CV;
        if (!in_range(a)) oor_m = 1'b1;
        @(negedge clk_i);
        check("rd_valid_early", data_r_valid, 0);
        check("rd_busy", busy_o, 1);
        buf_addr     = $urandom;
        buf_r_w      = 1'($urandom);
        buf_data_w   = 8'($urandom);
        data_w_valid = 1'b1;
        data_r_ready = (hold == 0);
        @(negedge clk_i);
        check("rd_valid", data_r_valid, 1);
        check("rd_data", buf_data_r, exp);
        check("rd_no_wr_ack", data_w_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            check("hold_valid", data_r_valid, 1);
            check("hold_data", buf_data_r, exp);
            if (i == hold - 1) data_r_ready = 1'b1;
        end
        @(posedge clk_i);
        #1;
        data_r_ready = 1'b0;
        data_w_valid = 1'b0;
        buf_r_w      = 1'b0;
        check("rd_after_xfer", data_r_valid, 0);
        check("rd_oor", oor_o, oor_m);
    endtask

`ifdef ZMEM_CLEAR_EN
    task automatic start_clear(input bit with_write, input logic [31:0] a, input logic [7:0] d);
        @(negedge clk_i);
        clear_i = 1'b1;
        if (with_write) begin
            buf_r_w      = 1'b0;
            buf_addr     = a;
            buf_data_w   = d;
            data_w_valid = 1'b1;
            #1 check("coll_wr_ready", data_w_ready, 0);
        end
        @(posedge clk_i);
        #1;
        clear_i      = 1'b0;
        data_w_valid = 1'b0;
    endtask

    task automatic wait_clear_done();
        int  n    = 0;
        bit  seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk_i);
            if (k == 1) begin
                check("clr_busy", busy_o, 1);
                check("clr_oor_cleared", oor_o, 0);
                check("clr_no_wr_ack", data_w_ready, 0);
            end
            if (clear_done_o) begin
                seen = 1'b1;
                n    = k;
            end
        end
        check("clear_done_cycle", n, 17);
        if (seen) begin
            @(negedge clk_i);
            check("clear_done_pulse", clear_done_o, 0);
        end
        for (int i = 0; i < DW; i++) mem_m[i] = CV;
        oor_m = 1'b0;
    endtask
`endif

    initial begin
        rst_i              = 1'b1;
        buf_base_address_i = BASE;
        buf_r_w            = 1'b0;
        buf_addr           = '0;
        buf_data_w         = '0;
        data_r_ready       = 1'b0;
        data_w_valid       = 1'b0;
        clear_i            = 1'b0;
        oor_m              = 1'b0;
        for (int i = 0; i < DW; i++) mem_m[i] = 8'h00;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_valid", data_r_valid, 0);
        check("rst_data", buf_data_r, 0);
        check("rst_done", clear_done_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_oor", oor_o, 0);
        check("rst_wr_ready", data_w_ready, 0);
        rst_i = 1'b0;

`ifdef ZMEM_CLEAR_EN
        start_clear(1'b0, '0, '0);
        wait_clear_done();
        do_read(BASE + 32'h5, 0);
`else
        for (int i = 0; i < DW; i++) do_write(BASE + 32'(i), CV);
`endif

        do_write(BASE + 32'hF, 8'h3A);
        do_read(BASE + 32'hF, 0);
        do_read(BASE, 4);

        do_write(BASE - 32'h1, 8'h55);
        check("oor_write_flag", oor_o, 1);
        do_read(BASE + 32'h10, 0);
        for (int i = 0; i < DW; i++) do_read(BASE + 32'(i), 0);

`ifdef ZMEM_CLEAR_EN
        start_clear(1'b0, '0, '0);
        wait_clear_done();
        check("oor_after_clear", oor_o, 0);

        start_clear(1'b1, BASE + 32'h3, 8'h11);
        wait_clear_done();
        do_read(BASE + 32'h3, 0);

        // Clear pulsed while the response is stalled: sweep must follow the transfer.
        @(negedge clk_i);
        buf_r_w      = 1'b1;
        buf_addr     = BASE;
        data_r_ready = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        data_r_ready = 1'b0;
        buf_r_w      = 1'b0;
        @(negedge clk_i);
        check("pend_valid", data_r_valid, 1);
        check("pend_data", buf_data_r, mem_m[0]);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check("pend_still_valid", data_r_valid, 1);
        data_r_ready = 1'b1;
        @(posedge clk_i);
        #1 data_r_ready = 1'b0;
        check("pend_xfer", data_r_valid, 0);
        wait_clear_done();
`else
        @(negedge clk_i);
        clear_i      = 1'b1;
        buf_r_w      = 1'b0;
        buf_addr     = BASE + 32'h1;
        buf_data_w   = 8'h42;
        data_w_valid = 1'b1;
        #1 check("noclr_wr_ready", data_w_ready, 1);
        @(posedge clk_i);
        #1;
        clear_i      = 1'b0;
        data_w_valid = 1'b0;
        mem_m[1]     = 8'h42;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (k == 0 || k == 19) begin
                check("noclr_busy", busy_o, 0);
                check("noclr_done", clear_done_o, 0);
                check("noclr_oor_kept", oor_o, oor_m);
            end
        end
        do_read(BASE + 32'h1, 0);
`endif

        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = BASE - 32'h2 + 32'($urandom_range(0, 19));
            if ($urandom_range(0, 1) == 0) do_write(a, 8'($urandom));
            else do_read(a, int'($urandom_range(0, 3)));
        end

`ifdef ZMEM_CLEAR_EN
        for (int i = 0; i < DW; i++) do_write(BASE + 32'(i), 8'(i * 13 + 7));
        do_write(BASE + 32'h20, 8'h99);
        do_read(BASE + 32'h2, 0);
        start_clear(1'b0, '0, '0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_i);
            if (k == 5) rst_i = 1'b1;
        end
        @(posedge clk_i);
        #1;
        check("rstclr_valid", data_r_valid, 0);
        check("rstclr_data", buf_data_r, 0);
        check("rstclr_done", clear_done_o, 0);
        check("rstclr_busy", busy_o, 0);
        check("rstclr_oor", oor_o, 0);
        rst_i = 1'b0;
        oor_m = 1'b0;
        begin
            int pulses = 0;
            for (int k = 0; k < 25; k++) begin
                @(negedge clk_i);
                if (clear_done_o) pulses++;
            end
            check("rstclr_no_done", pulses, 0);
        end
        for (int i = 0; i < 3; i++) mem_m[i] = CV;
        for (int i = 0; i < DW; i++) begin
            if (i < 3 || i > 5) do_read(BASE + 32'(i), 0);
        end
        for (int i = 3; i <= 5; i++) do_write(BASE + 32'(i), 8'(i + 100));
`endif

        for (int i = 0; i < DW; i++) do_read(BASE + 32'(i), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
